gcd_arbiter: RTL and testbench
==============================

Name: gcd_arbiter

Overview:
- Shares one multi-cycle GCD custom-instruction core among NUM_REQ requesters.
- Arbitration is round-robin.
- Sequences the core's start/done handshake.
- Short-circuits zero operands without dispatching them.
- Aborts the core with a pulse on its reset if it exceeds a cycle budget.
- Sits between the requesting masters and the single GCD core.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- TIMEOUT, 1024: maximum WAIT cycles allowed before an abort.
- CW, 11: counter width; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request; held until the matching req_ready.
- req_a  in  32*NUM_REQ  operand A; slice i belongs to requester i.
- req_b  in  32*NUM_REQ  operand B; slice i belongs to requester i.
- req_ready  out  NUM_REQ  one-hot, one-cycle grant/accept.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle response strobe.
- rsp_result  out  32  result; valid while any rsp_valid bit is high.
- rsp_err  out  1  timeout flag; qualified by rsp_valid.
- core_clk_en  out  1  constant 1 except during reset.
- core_reset  out  1  active-high core reset; registered.
- core_start  out  1  core start strobe.
- core_dataa  out  32  core operand A.
- core_datab  out  32  core operand B.
- core_done  in  1  core one-cycle done pulse.
- core_result  in  32  core result, valid with core_done.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State returns to IDLE; last_grant = NUM_REQ-1; counter = 0.
  - All outputs 0 except core_reset = 1.
  - core_reset drops on the first clk edge after reset_n rises.
- States: IDLE, ISSUE, WAIT, ABORT, RESP.
- IDLE:
  - Grant g = first i with req_valid[i], searching from last_grant+1 upward with wrap.
  - req_ready[g] = 1 combinationally in this cycle; nothing else asserts.
  - On the edge: latch req_a[g] and req_b[g] into opA/opB, latch g, set last_grant = g.
  - If opA==0 or opB==0: result = opA|opB (so gcd(0,0)=0), err = 0, next state RESP.
  - Otherwise next state ISSUE.
  - No valid request: stay in IDLE.
- ISSUE:
  - core_start = 1 and core_dataa/core_datab = opA/opB, all registered (high for exactly this cycle).
  - Counter cleared; next state WAIT.
- WAIT:
  - core_start = 0; the counter increments each cycle.
  - core_done = 1: latch core_result, err = 0, next state RESP. core_done wins over a timeout in the same cycle.
  - Otherwise, if counter == TIMEOUT-1: next state ABORT.
- ABORT:
  - core_reset = 1 for exactly one cycle.
  - result = 0, err = 1; next state RESP.
- RESP:
  - rsp_valid[g] = 1 for one cycle, with rsp_result and rsp_err driven.
  - Next state IDLE.
  - The requester may reassert req_valid in this same cycle. It is considered in the following IDLE cycle at the lowest round-robin priority.
- Latency from grant cycle G:
  - Zero-operand path: rsp_valid at G+1.
  - Dispatched path: rsp_valid at G+4+k, where k is the core's subtraction-step count (k = 0 when A == B).
  - Timeout path: rsp_valid at G+3+TIMEOUT.
- Ordering and fairness:
  - Exactly one transaction in flight; no pipelining.
  - A requester waits at most NUM_REQ-1 transactions before being granted.
- Operand handling:
  - Operands are unsigned 32-bit and are not modified by the arbiter.
  - The arbiter ignores a core_done seen outside WAIT.
  - req_valid deasserting before grant is legal; that request is simply dropped from arbitration.
- Reset mid-transaction:
  - The transaction is lost and no rsp_valid is issued.
  - core_reset is asserted so the core is flushed.
- Output encoding: rsp_valid and req_ready are never multi-hot.

Test Plan:
- Single request, requester 0, A=12 B=18 -> core_start 1 cycle after grant; rsp_valid[0] at G+6 with rsp_result=6, rsp_err=0.
- Requester 2, A=0 B=35 -> core_start never asserts; rsp_valid[2] at G+1 with rsp_result=35. Also A=0 B=0 -> rsp_result=0.
- All four req_valid held high from reset, every requester with A=B=7 -> grant order 0,1,2,3,0; each response is 7 and arrives at G+4.
- TIMEOUT=16 with a stub core that never asserts done -> core_reset high 1 cycle at G+18; rsp_valid at G+19 with rsp_err=1, rsp_result=0. The next request is then served normally.
- Stub core asserts core_done in the same cycle the counter hits TIMEOUT-1 -> normal response with rsp_err=0, and no core_reset.
- reset_n pulsed low during WAIT -> all outputs cleared immediately, core_reset=1, no rsp_valid. A new request after release completes correctly.

Source files
------------

// File: rtl/gcd_arbiter.sv
// Round-robin front end that shares one multi-cycle GCD core among NUM_REQ requesters.
// Zero operands bypass the core entirely, and a core that overruns its cycle budget is aborted.
module gcd_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1024,
    parameter int CW      = 11
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [31:0]           rsp_result,
    output logic                  rsp_err,
    output logic                  core_clk_en,
    output logic                  core_reset,
    output logic                  core_start,
    output logic [31:0]           core_dataa,
    output logic [31:0]           core_datab,
    input  logic                  core_done,
    input  logic [31:0]           core_result
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ABORT, RESP} state_t;

    state_t        state;
    state_t        state_next;
    logic          running;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] cur_grant;
    logic [IW-1:0] grant_idx;
    logic [IW-1:0] cand;
    int            rr_idx;
    logic          grant_found;
    logic          grant_ok;
    logic          zero_op;
    logic [31:0]   sel_a;
    logic [31:0]   sel_b;
    logic [31:0]   result;
    logic          err;
    logic [CW-1:0] counter;

    // Search upward from the requester after last_grant, wrapping, so the
    // most recently served requester always ends up with the lowest priority.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        rr_idx      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_idx = int'(last_grant) + k;
            if (rr_idx >= NUM_REQ) begin
                rr_idx = rr_idx - NUM_REQ;
            end
            cand = IW'(rr_idx);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IW'(i)) begin
                sel_a = req_a[32*i +: 32];
                sel_b = req_b[32*i +: 32];
            end
        end
    end

    // running stays low while reset is held, which keeps every grant quiet during reset.
    assign grant_ok    = running && (state == IDLE) && grant_found;
    assign zero_op     = (sel_a == 32'd0) || (sel_b == 32'd0);
    assign core_clk_en = running;

    always_comb begin
        req_ready = '0;
        if (grant_ok) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rsp_valid  = '0;
        rsp_result = '0;
        rsp_err    = 1'b0;
        if (state == RESP) begin
            rsp_valid[cur_grant] = 1'b1;
            rsp_result           = result;
            rsp_err              = err;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_ok) begin
                    state_next = zero_op ? RESP : ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (core_done) begin
                    state_next = RESP;
                end else if (counter == LAST_COUNT) begin
                    state_next = ABORT;
                end
            end
            ABORT:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // core_start and core_reset are registered, so each is raised on the edge
    // that enters ISSUE or ABORT and therefore lasts exactly that one state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            running    <= 1'b0;
            last_grant <= IW'(NUM_REQ - 1);
            cur_grant  <= '0;
            result     <= '0;
            err        <= 1'b0;
            counter    <= '0;
            core_reset <= 1'b1;
            core_start <= 1'b0;
            core_dataa <= '0;
            core_datab <= '0;
        end else begin
            running    <= 1'b1;
            core_reset <= 1'b0;
            core_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_ok) begin
                        cur_grant  <= grant_idx;
                        last_grant <= grant_idx;
                        core_dataa <= sel_a;
                        core_datab <= sel_b;
                        if (zero_op) begin
                            result <= sel_a | sel_b;
                            err    <= 1'b0;
                        end else begin
                            core_start <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    counter <= '0;
                end
                WAIT: begin
                    counter <= counter + CW'(1);
                    if (core_done) begin
                        result <= core_result;
                        err    <= 1'b0;
                    end else if (counter == LAST_COUNT) begin
                        core_reset <= 1'b1;
                    end
                end
                ABORT: begin
                    result <= '0;
                    err    <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Testbench for gcd_arbiter: a behavioural GCD core stub plus per-scenario tasks,
// with expectations derived from plain arithmetic (Euclid, subtraction-step count, latency rules).
module tb_gcd_arbiter;
    localparam int NR   = 4;
    localparam int TO   = 16;
    localparam int CWID = 5;

    logic            clk;
    logic            reset_n;
    logic [NR-1:0]   req_valid;
    logic [32*NR-1:0] req_a;
    logic [32*NR-1:0] req_b;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   rsp_valid;
    logic [31:0]     rsp_result;
    logic            rsp_err;
    logic            core_clk_en;
    logic            core_reset;
    logic            core_start;
    logic [31:0]     core_dataa;
    logic [31:0]     core_datab;
    logic            core_done;
    logic [31:0]     core_result;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    // Stub core controls: 0 = normal, 1 = never done, 2 = done after force_k steps.
    int          core_mode = 0;
    int          force_k   = 0;
    logic [31:0] cap_a = '0;
    logic [31:0] cap_b = '0;
    bit          busy;
    int          cnt;
    int          steps;
    logic [31:0] pend;
    logic [31:0] a_w;
    logic [31:0] b_w;

    gcd_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO), .CW(CWID)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_err(rsp_err),
        .core_clk_en(core_clk_en), .core_reset(core_reset), .core_start(core_start),
        .core_dataa(core_dataa), .core_datab(core_datab),
        .core_done(core_done), .core_result(core_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int sub_steps(input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (a != b && a != 0 && b != 0 && n < 1000) begin
            if (a > b) a = a - b;
            else b = b - a;
            n++;
        end
        return n;
    endfunction

    function automatic int first_set(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int next_rr(input int last, input logic [NR-1:0] mask);
        for (int d = 1; d <= NR; d++) if (mask[(last + d) % NR]) return (last + d) % NR;
        return -1;
    endfunction

    // The core sees start at the falling edge and raises done k+2 falling edges
    // later, so the arbiter samples done in cycle G+3+k.
    initial begin
        core_done = 1'b0;
        core_result = '0;
        busy = 1'b0;
        cnt = 0;
        pend = '0;
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            if (!reset_n || core_reset) begin
                busy = 1'b0;
            end else if (busy) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    core_done = 1'b1;
                    core_result = pend;
                    busy = 1'b0;
                end
            end else if (core_start) begin
                cap_a = core_dataa;
                cap_b = core_datab;
                a_w = core_dataa;
                b_w = core_datab;
                steps = 0;
                while (a_w != b_w && a_w != 0 && b_w != 0 && steps < 1000) begin
                    if (a_w > b_w) a_w = a_w - b_w;
                    else b_w = b_w - a_w;
                    steps++;
                end
                pend = (a_w == 0 || b_w == 0) ? (a_w | b_w) : a_w;
                if (core_mode != 1) begin
                    cnt = ((core_mode == 2) ? force_k : steps) + 2;
                    busy = 1'b1;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1);
    end

    // Runs one transaction for requester r and reports what was observed.
    task automatic do_txn(input int r, input logic [31:0] a, input logic [31:0] b,
                          output int g_cyc, output int rsp_cyc, output logic [NR-1:0] rsp_vec,
                          output logic [31:0] res, output logic err,
                          output int start_cnt, output int start_cyc,
                          output int crst_cnt, output int crst_cyc, output bit expired);
        bit got = 1'b0;
        g_cyc = -1; rsp_cyc = -1; rsp_vec = '0; res = '0; err = 1'b0;
        start_cnt = 0; start_cyc = -1; crst_cnt = 0; crst_cyc = -1; expired = 1'b0;
        @(posedge clk); #1;
        req_a[r*32 +: 32] = a;
        req_b[r*32 +: 32] = b;
        req_valid[r] = 1'b1;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (req_ready[r]) begin
                got = 1'b1;
                g_cyc = cyc;
            end
        end
        if (!got) begin
            expired = 1'b1;
            req_valid[r] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (core_start) begin start_cnt++; start_cyc = cyc; end
            if (core_reset) begin crst_cnt++; crst_cyc = cyc; end
            if (rsp_valid != 0) begin
                got = 1'b1;
                rsp_cyc = cyc;
                rsp_vec = rsp_valid;
                res = rsp_result;
                err = rsp_err;
            end
        end
        if (!got) expired = 1'b1;
    endtask

    task automatic test_reset();
        req_valid = '1;
        for (int i = 0; i < NR; i++) begin
            req_a[i*32 +: 32] = 32'd7;
            req_b[i*32 +: 32] = 32'd7;
        end
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++; if (req_ready !== '0) begin tests_failed++; $display("[TB] FAIL reset_req_ready: got %b, expected 0", req_ready); end
        tests_run++; if (rsp_valid !== '0) begin tests_failed++; $display("[TB] FAIL reset_rsp_valid: got %b, expected 0", rsp_valid); end
        tests_run++; if (core_start !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_core_start: got %b, expected 0", core_start); end
        tests_run++; if (core_reset !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_core_reset: got %b, expected 1", core_reset); end
        tests_run++; if (core_clk_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_clk_en: got %b, expected 0", core_clk_en); end
        tests_run++; if (core_dataa !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_dataa: got %0d, expected 0", core_dataa); end
        tests_run++; if (rsp_result !== 32'd0 || rsp_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rsp: got %0d/%b, expected 0/0", rsp_result, rsp_err); end
        reset_n = 1'b1;
        @(negedge clk);
        tests_run++; if (core_reset !== 1'b0) begin tests_failed++; $display("[TB] FAIL release_core_reset: got %b, expected 0", core_reset); end
        tests_run++; if (core_clk_en !== 1'b1) begin tests_failed++; $display("[TB] FAIL release_clk_en: got %b, expected 1", core_clk_en); end
    endtask

    // Continues straight from test_reset with all four requesters held valid.
    task automatic test_round_robin();
        int g_idx[5]; int g_cyc[5]; int r_idx[5]; int r_cyc[5];
        logic [31:0] r_res[5]; logic r_err[5];
        int ng = 0; int nr = 0; int last = NR - 1; int exp_g;
        for (int n = 0; n < 120 && nr < 5; n++) begin
            if (n > 0) @(negedge clk);
            if (rsp_valid != 0) begin
                tests_run++; if (!$onehot(rsp_valid)) begin tests_failed++; $display("[TB] FAIL rr_rsp_onehot: got %b, expected one-hot", rsp_valid); end
                if (nr < 5) begin
                    r_idx[nr] = first_set(rsp_valid); r_cyc[nr] = cyc;
                    r_res[nr] = rsp_result; r_err[nr] = rsp_err; nr++;
                end
            end
            if (req_ready != 0 && ng < 5) begin
                tests_run++; if (!$onehot(req_ready)) begin tests_failed++; $display("[TB] FAIL rr_ready_onehot: got %b, expected one-hot", req_ready); end
                g_idx[ng] = first_set(req_ready); g_cyc[ng] = cyc; ng++;
                if (ng == 5) begin
                    @(posedge clk); #1;
                    req_valid = '0;
                end
            end
        end
        tests_run++; if (nr != 5) begin tests_failed++; $display("[TB] FAIL rr_responses: got %0d, expected 5", nr); end
        for (int i = 0; i < nr && i < ng; i++) begin
            exp_g = next_rr(last, '1);
            last = exp_g;
            tests_run++; if (g_idx[i] != exp_g) begin tests_failed++; $display("[TB] FAIL rr_grant%0d: got %0d, expected %0d", i, g_idx[i], exp_g); end
            tests_run++; if (r_idx[i] != g_idx[i]) begin tests_failed++; $display("[TB] FAIL rr_rsp_idx%0d: got %0d, expected %0d", i, r_idx[i], g_idx[i]); end
            tests_run++; if (r_cyc[i] != g_cyc[i] + 4) begin tests_failed++; $display("[TB] FAIL rr_latency%0d: got %0d, expected %0d", i, r_cyc[i] - g_cyc[i], 4); end
            tests_run++; if (r_res[i] !== ref_gcd(7, 7) || r_err[i] !== 1'b0) begin tests_failed++; $display("[TB] FAIL rr_result%0d: got %0d/%b, expected 7/0", i, r_res[i], r_err[i]); end
        end
    endtask

    task automatic test_single();
        int g, rc, sc, sn, cc, cn; logic [NR-1:0] v; logic [31:0] res; logic e; bit ex;
        core_mode = 0;
        do_txn(0, 32'd12, 32'd18, g, rc, v, res, e, sn, sc, cn, cc, ex);
        tests_run++; if (ex) begin tests_failed++; $display("[TB] FAIL single_expired: got timeout, expected response"); end
        tests_run++; if (sn != 1 || sc != g + 1) begin tests_failed++; $display("[TB] FAIL single_start: got %0d strobes at G+%0d, expected 1 at G+1", sn, sc - g); end
        tests_run++; if (cap_a !== 32'd12 || cap_b !== 32'd18) begin tests_failed++; $display("[TB] FAIL single_operands: got %0d,%0d, expected 12,18", cap_a, cap_b); end
        tests_run++; if (v !== 4'b0001) begin tests_failed++; $display("[TB] FAIL single_rsp_vec: got %b, expected 0001", v); end
        tests_run++; if (rc != g + 4 + sub_steps(12, 18)) begin tests_failed++; $display("[TB] FAIL single_latency: got G+%0d, expected G+%0d", rc - g, 4 + sub_steps(12, 18)); end
        tests_run++; if (res !== ref_gcd(12, 18) || e !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_result: got %0d/%b, expected %0d/0", res, e, ref_gcd(12, 18)); end
        tests_run++; if (cn != 0) begin tests_failed++; $display("[TB] FAIL single_core_reset: got %0d pulses, expected 0", cn); end
    endtask

    task automatic test_zero();
        int zr[3] = '{2, 2, 1};
        logic [31:0] za[3] = '{32'd0, 32'd0, 32'd9};
        logic [31:0] zb[3] = '{32'd35, 32'd0, 32'd0};
        int g, rc, sc, sn, cc, cn; logic [NR-1:0] v; logic [31:0] res; logic e; bit ex;
        logic [NR-1:0] exp_v;
        for (int i = 0; i < 3; i++) begin
            do_txn(zr[i], za[i], zb[i], g, rc, v, res, e, sn, sc, cn, cc, ex);
            exp_v = '0; exp_v[zr[i]] = 1'b1;
            tests_run++; if (ex || sn != 0) begin tests_failed++; $display("[TB] FAIL zero%0d_start: got %0d strobes (expired %0d), expected 0", i, sn, ex); end
            tests_run++; if (rc != g + 1) begin tests_failed++; $display("[TB] FAIL zero%0d_latency: got G+%0d, expected G+1", i, rc - g); end
            tests_run++; if (v !== exp_v) begin tests_failed++; $display("[TB] FAIL zero%0d_rsp_vec: got %b, expected %b", i, v, exp_v); end
            tests_run++; if (res !== ref_gcd(za[i], zb[i]) || e !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero%0d_result: got %0d/%b, expected %0d/0", i, res, e, ref_gcd(za[i], zb[i])); end
        end
    endtask

    task automatic test_timeout();
        int g, rc, sc, sn, cc, cn; logic [NR-1:0] v; logic [31:0] res; logic e; bit ex;
        core_mode = 1;
        do_txn(1, 32'd20, 32'd30, g, rc, v, res, e, sn, sc, cn, cc, ex);
        tests_run++; if (ex || sn != 1) begin tests_failed++; $display("[TB] FAIL timeout_start: got %0d strobes (expired %0d), expected 1", sn, ex); end
        tests_run++; if (cn != 1 || cc != g + 2 + TO) begin tests_failed++; $display("[TB] FAIL timeout_core_reset: got %0d pulses at G+%0d, expected 1 at G+%0d", cn, cc - g, 2 + TO); end
        tests_run++; if (rc != g + 3 + TO) begin tests_failed++; $display("[TB] FAIL timeout_latency: got G+%0d, expected G+%0d", rc - g, 3 + TO); end
        tests_run++; if (v !== 4'b0010 || res !== 32'd0 || e !== 1'b1) begin tests_failed++; $display("[TB] FAIL timeout_rsp: got %b/%0d/%b, expected 0010/0/1", v, res, e); end
        core_mode = 0;
        do_txn(3, 32'd9, 32'd6, g, rc, v, res, e, sn, sc, cn, cc, ex);
        tests_run++; if (ex || rc != g + 4 + sub_steps(9, 6)) begin tests_failed++; $display("[TB] FAIL after_timeout_latency: got G+%0d, expected G+%0d", rc - g, 4 + sub_steps(9, 6)); end
        tests_run++; if (v !== 4'b1000 || res !== ref_gcd(9, 6) || e !== 1'b0 || cn != 0) begin tests_failed++; $display("[TB] FAIL after_timeout_rsp: got %b/%0d/%b, expected 1000/%0d/0", v, res, e, ref_gcd(9, 6)); end
    endtask

    task automatic test_done_at_timeout();
        int g, rc, sc, sn, cc, cn; logic [NR-1:0] v; logic [31:0] res; logic e; bit ex;
        core_mode = 2;
        force_k = TO - 2;
        do_txn(0, 32'd21, 32'd14, g, rc, v, res, e, sn, sc, cn, cc, ex);
        core_mode = 0;
        tests_run++; if (ex || rc != g + 4 + (TO - 2)) begin tests_failed++; $display("[TB] FAIL edge_latency: got G+%0d, expected G+%0d", rc - g, 2 + TO); end
        tests_run++; if (res !== ref_gcd(21, 14) || e !== 1'b0) begin tests_failed++; $display("[TB] FAIL edge_result: got %0d/%b, expected %0d/0", res, e, ref_gcd(21, 14)); end
        tests_run++; if (cn != 0) begin tests_failed++; $display("[TB] FAIL edge_core_reset: got %0d pulses, expected 0", cn); end
    endtask

    task automatic test_reset_mid();
        int g, rc, sc, sn, cc, cn; logic [NR-1:0] v; logic [31:0] res; logic e; bit ex;
        bit got = 1'b0; int seen = 0;
        core_mode = 1;
        @(posedge clk); #1;
        req_a[2*32 +: 32] = 32'd5;
        req_b[2*32 +: 32] = 32'd10;
        req_valid[2] = 1'b1;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (req_ready[2]) got = 1'b1;
        end
        tests_run++; if (!got) begin tests_failed++; $display("[TB] FAIL mid_grant: got no grant, expected grant"); end
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        req_valid[1] = 1'b1;
        #1;
        tests_run++; if (rsp_valid !== '0 || req_ready !== '0) begin tests_failed++; $display("[TB] FAIL mid_strobes: got %b/%b, expected 0/0", rsp_valid, req_ready); end
        tests_run++; if (core_reset !== 1'b1 || core_start !== 1'b0 || core_clk_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_core: got rst %b start %b en %b, expected 1 0 0", core_reset, core_start, core_clk_en); end
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid != 0) seen++;
        end
        tests_run++; if (seen != 0) begin tests_failed++; $display("[TB] FAIL mid_no_rsp: got %0d strobes, expected 0", seen); end
        req_valid[1] = 1'b0;
        reset_n = 1'b1;
        core_mode = 0;
        do_txn(2, 32'd5, 32'd10, g, rc, v, res, e, sn, sc, cn, cc, ex);
        tests_run++; if (ex || rc != g + 4 + sub_steps(5, 10)) begin tests_failed++; $display("[TB] FAIL mid_recover_latency: got G+%0d, expected G+%0d", rc - g, 4 + sub_steps(5, 10)); end
        tests_run++; if (v !== 4'b0100 || res !== ref_gcd(5, 10) || e !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_recover_rsp: got %b/%0d/%b, expected 0100/%0d/0", v, res, e, ref_gcd(5, 10)); end
    endtask

    // Random single requests; slow pairs (many subtraction steps) are expected to time out.
    task automatic test_random();
        int g, rc, sc, sn, cc, cn; logic [NR-1:0] v; logic [31:0] res; logic e; bit ex;
        int r, k, exp_lat, exp_start; logic [31:0] a, b, exp_res; logic exp_err;
        logic [NR-1:0] exp_v;
        core_mode = 0;
        for (int i = 0; i < 14; i++) begin
            r = $urandom_range(0, NR - 1);
            a = 32'($urandom_range(0, 24));
            b = 32'($urandom_range(0, 24));
            if (a == 0 || b == 0) begin
                exp_lat = 1; exp_res = ref_gcd(a, b); exp_err = 1'b0; exp_start = 0;
            end else begin
                k = sub_steps(a, b);
                exp_start = 1;
                if (k <= TO - 2) begin
                    exp_lat = 4 + k; exp_res = ref_gcd(a, b); exp_err = 1'b0;
                end else begin
                    exp_lat = 3 + TO; exp_res = 32'd0; exp_err = 1'b1;
                end
            end
            exp_v = '0; exp_v[r] = 1'b1;
            do_txn(r, a, b, g, rc, v, res, e, sn, sc, cn, cc, ex);
            tests_run++; if (ex || rc != g + exp_lat) begin tests_failed++; $display("[TB] FAIL rand%0d_latency (%0d,%0d): got G+%0d, expected G+%0d", i, a, b, rc - g, exp_lat); end
            tests_run++; if (v !== exp_v || sn != exp_start) begin tests_failed++; $display("[TB] FAIL rand%0d_route: got %b start %0d, expected %b start %0d", i, v, sn, exp_v, exp_start); end
            tests_run++; if (res !== exp_res || e !== exp_err) begin tests_failed++; $display("[TB] FAIL rand%0d_result (%0d,%0d): got %0d/%b, expected %0d/%b", i, a, b, res, e, exp_res, exp_err); end
        end
    endtask

    initial begin
        reset_n = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        #2;
        test_reset();
        test_round_robin();
        test_single();
        test_zero();
        test_timeout();
        test_done_at_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
